// File: rtl/ras_circ_pkg.sv
// Shared core types for branch prediction: return-address stack entry, RAS checkpoint,
// core configuration, and the pointer-wrap helpers used by the circular return stack.
package ras_circ_pkg;

    // The struct fields are sized for the widest legal configuration:
    // VLEN up to 64 bits and DEPTH up to 64 entries.
    localparam int unsigned RAS_VLEN_MAX  = 64;
    localparam int unsigned RAS_PTR_W_MAX = 6;
    localparam int unsigned RAS_CNT_W_MAX = 7;

    typedef struct packed {
        logic                    valid;
        logic [RAS_VLEN_MAX-1:0] ra;
    } ras_t;

    typedef struct packed {
        logic [RAS_PTR_W_MAX-1:0] ptr;
        logic [RAS_CNT_W_MAX-1:0] count;
        ras_t                     top;
    } ras_ckpt_t;

    typedef enum logic [2:0] {
        RAS_NONE,
        RAS_PUSH,
        RAS_POP,
        RAS_SWAP,
        RAS_FLUSH,
        RAS_RESTORE
    } ras_op_e;

    typedef struct packed {
        int unsigned RASDepth;
        int unsigned BHTEntries;
        int unsigned BTBEntries;
    } cva6_cfg_t;

    localparam cva6_cfg_t CVA6Cfg = '{RASDepth: 32'd2, BHTEntries: 32'd128, BTBEntries: 32'd32};

    function automatic int unsigned ras_wrap_inc(input int unsigned ptr, input int unsigned depth);
        return (ptr + 1 == depth) ? 0 : ptr + 1;
    endfunction

    function automatic int unsigned ras_wrap_dec(input int unsigned ptr, input int unsigned depth);
        return (ptr == 0) ? depth - 1 : ptr - 1;
    endfunction

endpackage

// File: rtl/ras_circ.sv
// Circular return-address stack: full pushes overwrite the oldest entry, and a single-level
// checkpoint of pointer, count and top entry allows rollback after a misprediction.
module ras_circ
    import ras_circ_pkg::*;
#(
    parameter int unsigned DEPTH   = CVA6Cfg.RASDepth,
    parameter int unsigned VLEN    = 64,
    parameter bit          CKPT_EN = 1'b1
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [VLEN-1:0]            data_i,
    input  logic                       ckpt_i,
    input  logic                       restore_i,
    output logic [VLEN-1:0]            data_o,
    output logic                       valid_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int unsigned PTR_W = (DEPTH > 2) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [VLEN-1:0]  mem_q [DEPTH];
    logic [PTR_W-1:0] ptr_q, ptr_d, ptr_inc, ptr_dec;
    logic [CNT_W-1:0] count_q, count_d;
    logic             wr_en;
    logic [PTR_W-1:0] wr_ptr;
    logic [VLEN-1:0]  wr_data;
    logic [VLEN-1:0]  top;
    logic             restore_en;
    ras_op_e          op;
    ras_ckpt_t        ckpt_q, ckpt_live;
    logic             unused_ckpt;

    assign top        = (count_q == '0) ? '0 : mem_q[ptr_q];
    assign restore_en = CKPT_EN && restore_i;
    assign ptr_inc    = PTR_W'(ras_wrap_inc(32'(ptr_q), DEPTH));
    assign ptr_dec    = PTR_W'(ras_wrap_dec(32'(ptr_q), DEPTH));

    // Restore and flush pre-empt the stack operations; an empty-stack pop is dropped here.
    always_comb begin
        op = RAS_NONE;
        if (flush_i)                     op = RAS_FLUSH;
        else if (restore_en)             op = RAS_RESTORE;
        else if (push_i && pop_i)        op = RAS_SWAP;
        else if (push_i)                 op = RAS_PUSH;
        else if (pop_i && count_q != '0) op = RAS_POP;
    end

    // NOTE: every output of this block gets a default first so no path can infer a latch.
    always_comb begin
        ptr_d   = ptr_q;
        count_d = count_q;
        wr_en   = 1'b0;
        wr_ptr  = ptr_q;
        wr_data = data_i;
        case (op)
            RAS_FLUSH: begin
                ptr_d   = '0;
                count_d = '0;
            end
            RAS_RESTORE: begin
                ptr_d   = ckpt_q.ptr[PTR_W-1:0];
                count_d = ckpt_q.count[CNT_W-1:0];
                wr_en   = 1'b1;
                wr_ptr  = ckpt_q.ptr[PTR_W-1:0];
                wr_data = ckpt_q.top.ra[VLEN-1:0];
            end
            RAS_PUSH: begin
                ptr_d  = ptr_inc;
                wr_en  = 1'b1;
                wr_ptr = ptr_inc;
                if (count_q != CNT_W'(DEPTH)) count_d = count_q + 1'b1;
            end
            RAS_POP: begin
                ptr_d   = ptr_dec;
                count_d = count_q - 1'b1;
            end
            RAS_SWAP: begin
                wr_en = 1'b1;
                if (count_q == '0) count_d = CNT_W'(1);
            end
            default: ;
        endcase
    end

    // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q   <= '0;
            count_q <= '0;
        end else begin
            ptr_q   <= ptr_d;
            count_q <= count_d;
        end
    end

    // NOTE: the entry array has no reset; live entries are always written before they are read.
    always_ff @(posedge clk_i) begin
        if (wr_en) mem_q[wr_ptr] <= wr_data;
    end

    assign ckpt_live = '{
        ptr:   RAS_PTR_W_MAX'(ptr_q),
        count: RAS_CNT_W_MAX'(count_q),
        top:   '{valid: (count_q != '0), ra: RAS_VLEN_MAX'(top)}
    };

    if (CKPT_EN) begin : g_ckpt
        // A restore re-captures exactly what is already held, so restore+ckpt keeps ckpt_q.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                ckpt_q <= '0;
            end else if (flush_i) begin
                if (ckpt_i) ckpt_q <= '0;
            end else if (ckpt_i && !restore_i) begin
                ckpt_q <= ckpt_live;
            end
        end
    end else begin : g_no_ckpt
        assign ckpt_q = '0;
    end

    assign unused_ckpt = ^{ckpt_q, ckpt_live, ckpt_i, restore_i};

    assign data_o  = top;
    assign valid_o = (count_q != '0);
    assign count_o = count_q;

endmodule

// File: tb/tb_ras_circ.sv
// Scoreboard bench for ras_circ: DEPTH=2 and DEPTH=4 instances share stimulus; a stack model
// predicts the registered outputs and a monitor compares them one cycle after each request.
module tb_ras_circ;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        flush = 1'b0, push = 1'b0, pop = 1'b0, ckpt = 1'b0, restore = 1'b0;
    logic [63:0] data = '0;
    logic [63:0] data2, data4;
    logic        valid2, valid4;
    logic [1:0]  count2;
    logic [2:0]  count4;

    always #5 clk = ~clk;

    ras_circ #(.DEPTH(2), .VLEN(64), .CKPT_EN(1'b1)) dut2 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .push_i(push), .pop_i(pop),
        .data_i(data), .ckpt_i(ckpt), .restore_i(restore),
        .data_o(data2), .valid_o(valid2), .count_o(count2)
    );

    ras_circ #(.DEPTH(4), .VLEN(64), .CKPT_EN(1'b1)) dut4 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .push_i(push), .pop_i(pop),
        .data_i(data), .ckpt_i(ckpt), .restore_i(restore),
        .data_o(data4), .valid_o(valid4), .count_o(count4)
    );

    typedef struct {
        logic [63:0] data;
        bit          valid;
        int          count;
    } exp_t;

    exp_t  q2[$];
    exp_t  q4[$];
    exp_t  mon_e;
    int    n_checks = 0;
    int    n_fail = 0;
    string phase = "reset";

    // Reference stack: slot array, top index and live count per instance, plus its snapshot.
    int          m_ptr[2];
    int          m_cnt[2];
    logic [63:0] m_mem[2][4];
    int          s_ptr[2];
    int          s_cnt[2];
    logic [63:0] s_top[2];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s/%s: got %0h expected %0h at %0t", phase, name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            m_ptr[m] = 0;
            m_cnt[m] = 0;
            s_ptr[m] = 0;
            s_cnt[m] = 0;
            s_top[m] = '0;
        end
    endtask

    task automatic model_step(input int m, input bit fl, input bit ps, input bit pp,
                              input bit ck, input bit rs, input logic [63:0] d);
        int          dep;
        int          p;
        int          c;
        logic [63:0] top;
        dep = (m == 0) ? 2 : 4;
        p   = m_ptr[m];
        c   = m_cnt[m];
        top = (c == 0) ? 64'd0 : m_mem[m][p];
        if (fl) begin
            p = 0;
            c = 0;
            if (ck) begin
                s_ptr[m] = 0;
                s_cnt[m] = 0;
                s_top[m] = '0;
            end
        end else if (rs) begin
            p = s_ptr[m];
            c = s_cnt[m];
            m_mem[m][p] = s_top[m];
        end else begin
            if (ck) begin
                s_ptr[m] = p;
                s_cnt[m] = c;
                s_top[m] = top;
            end
            if (ps && pp) begin
                m_mem[m][p] = d;
                if (c == 0) c = 1;
            end else if (ps) begin
                p = (p + 1) % dep;
                m_mem[m][p] = d;
                if (c < dep) c++;
            end else if (pp && c > 0) begin
                p = (p + dep - 1) % dep;
                c--;
            end
        end
        m_ptr[m] = p;
        m_cnt[m] = c;
    endtask

    function automatic exp_t model_out(input int m);
        exp_t e;
        e.count = m_cnt[m];
        e.valid = (m_cnt[m] != 0);
        e.data  = (m_cnt[m] == 0) ? 64'd0 : m_mem[m][m_ptr[m]];
        return e;
    endfunction

    task automatic drive(input bit fl, input bit ps, input bit pp, input bit ck, input bit rs,
                         input logic [63:0] d);
        @(negedge clk);
        flush   = fl;
        push    = ps;
        pop     = pp;
        ckpt    = ck;
        restore = rs;
        data    = d;
        model_step(0, fl, ps, pp, ck, rs, d);
        model_step(1, fl, ps, pp, ck, rs, d);
        q2.push_back(model_out(0));
        q4.push_back(model_out(1));
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_d2_data"}, data2, 64'd0);
        check({tag, "_d2_valid"}, 64'(valid2), 64'd0);
        check({tag, "_d2_count"}, 64'(count2), 64'd0);
        check({tag, "_d4_data"}, data4, 64'd0);
        check({tag, "_d4_valid"}, 64'(valid4), 64'd0);
        check({tag, "_d4_count"}, 64'(count4), 64'd0);
    endtask

    // Monitor: each registered response is visible shortly after the edge that produced it.
    always @(posedge clk) begin
        #1;
        if (q2.size() > 0) begin
            mon_e = q2.pop_front();
            check("d2_data", data2, mon_e.data);
            check("d2_valid", 64'(valid2), 64'(mon_e.valid));
            check("d2_count", 64'(count2), 64'(mon_e.count));
        end
        if (q4.size() > 0) begin
            mon_e = q4.pop_front();
            check("d4_data", data4, mon_e.data);
            check("d4_valid", 64'(valid4), 64'(mon_e.valid));
            check("d4_count", 64'(count4), 64'(mon_e.count));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit          fl, ps, pp, ck, rs;
        logic [63:0] d;

        model_reset();
        for (int m = 0; m < 2; m++)
            for (int i = 0; i < 4; i++) m_mem[m][i] = '0;

        #2 rst_n = 1'b0;
        #1 check_zero_outputs("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        phase = "fill";
        for (int i = 0; i < 4; i++) drive(0, 1, 0, 0, 0, 64'h1110 + 64'(i));
        drive(1, 0, 0, 0, 0, 64'd0);

        phase = "push_pop";
        drive(0, 1, 0, 0, 0, 64'h1000);
        drive(0, 1, 0, 0, 0, 64'h2000);
        drive(0, 0, 1, 0, 0, 64'd0);

        phase = "wrap";
        drive(1, 0, 0, 0, 0, 64'd0);
        drive(0, 1, 0, 0, 0, 64'hA);
        drive(0, 1, 0, 0, 0, 64'hB);
        drive(0, 1, 0, 0, 0, 64'hC);
        drive(0, 0, 1, 0, 0, 64'd0);
        drive(0, 0, 1, 0, 0, 64'd0);
        drive(0, 0, 1, 0, 0, 64'd0);
        drive(0, 0, 1, 0, 0, 64'd0);
        drive(0, 0, 1, 0, 0, 64'd0);

        phase = "swap";
        drive(1, 0, 0, 0, 0, 64'd0);
        drive(0, 1, 0, 0, 0, 64'h40);
        drive(0, 1, 1, 0, 0, 64'h80);
        drive(1, 0, 0, 0, 0, 64'd0);
        drive(0, 1, 1, 0, 0, 64'h55);

        phase = "ckpt_restore";
        drive(1, 0, 0, 0, 0, 64'd0);
        drive(0, 1, 0, 0, 0, 64'h10);
        drive(0, 1, 0, 0, 0, 64'h20);
        drive(0, 0, 0, 1, 0, 64'd0);
        drive(0, 1, 0, 0, 0, 64'h30);
        drive(0, 0, 1, 0, 0, 64'd0);
        drive(0, 0, 1, 0, 0, 64'd0);
        drive(0, 0, 0, 0, 1, 64'd0);
        drive(0, 1, 0, 1, 1, 64'h77);
        idle();

        phase = "flush_prio";
        drive(0, 1, 0, 0, 0, 64'h5);
        drive(1, 1, 1, 0, 1, 64'h99);
        drive(0, 0, 0, 0, 1, 64'd0);
        drive(0, 1, 0, 0, 0, 64'h9);
        drive(1, 0, 0, 1, 0, 64'd0);
        drive(0, 1, 0, 0, 0, 64'h33);
        drive(0, 0, 0, 0, 1, 64'd0);

        phase = "async_reset";
        drive(0, 1, 0, 0, 0, 64'h1);
        drive(0, 1, 0, 0, 0, 64'h2);
        @(posedge clk);
        #2;
        flush = 1'b0; push = 1'b0; pop = 1'b0; ckpt = 1'b0; restore = 1'b0;
        rst_n = 1'b0;
        #1 check_zero_outputs("midreset");
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 1, 0, 0, 0, 64'h99);
        drive(0, 0, 0, 0, 1, 64'd0);

        phase = "random";
        for (int i = 0; i < 400; i++) begin
            fl = ($urandom_range(0, 99) < 3);
            ps = ($urandom_range(0, 1) == 1);
            pp = ($urandom_range(0, 2) == 0);
            ck = ($urandom_range(0, 9) == 0);
            rs = ($urandom_range(0, 11) == 0);
            d  = {$urandom, $urandom};
            drive(fl, ps, pp, ck, rs, d);
        end
        idle();

        phase = "drain";
        @(negedge clk);
        @(negedge clk);
        check("queues_empty", 64'(q2.size() + q4.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
